// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 11 device-clocked bits, ACK, release.
// Optional build macro PS2_TX_ACK_CHECK_EN turns a NACK from the device into a tx_error pulse.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 375000,
    parameter int CNT_W          = 19
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2clk,
    input  logic       ps2dat,
    output logic       ps2clk_oe,
    output logic       ps2dat_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       rx_inhibit
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INHIBIT  = 3'd1,
        ST_REQ      = 3'd2,
        ST_SEND     = 3'd3,
        ST_ACK      = 3'd4,
        ST_WAIT_REL = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    // Fires one cycle early so the registered tx_error lands exactly TIMEOUT_CYCLES after REQ.
    localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(TIMEOUT_CYCLES - 2);

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    // Frame position 0 is the start bit, 1..8 data LSB first, 9 parity, 10 and beyond stop.
    function automatic logic frame_bit(input logic [3:0] idx, input logic [7:0] d, input logic par);
        logic b;
        case (idx)
            4'd0:                                           b = 1'b0;
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: b = d[3'(idx - 4'd1)];
            4'd9:                                           b = par;
            default:                                        b = 1'b1;
        endcase
        return b;
    endfunction

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [3:0]       bitcnt_r;
    logic [7:0]       shreg_r;
    logic             parity_r;
`ifdef PS2_TX_ACK_CHECK_EN
    logic             ack_bit_r;
`endif
    logic             clk_meta_r, clk_sync_r, clk_prev_r;
    logic             dat_meta_r, dat_sync_r;
    logic             fe_s;
    logic [3:0]       next_idx_s;
    logic             next_bit_s;

    assign fe_s       = clk_prev_r & ~clk_sync_r;
    assign next_idx_s = bitcnt_r + 4'd1;
    assign next_bit_s = frame_bit(next_idx_s, shreg_r, parity_r);

    // Two-flop synchronisers for the asynchronous bus lines; idle bus reads high.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_meta_r <= 1'b1;
            clk_sync_r <= 1'b1;
            clk_prev_r <= 1'b1;
            dat_meta_r <= 1'b1;
            dat_sync_r <= 1'b1;
        end else begin
            clk_meta_r <= ps2clk;
            clk_sync_r <= clk_meta_r;
            clk_prev_r <= clk_sync_r;
            dat_meta_r <= ps2dat;
            dat_sync_r <= dat_meta_r;
        end
    end

    // Transfer FSM with registered line enables and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CNT_ZERO;
            bitcnt_r   <= 4'd0;
            shreg_r    <= 8'h00;
            parity_r   <= 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
            ack_bit_r  <= 1'b0;
`endif
            ps2clk_oe  <= 1'b0;
            ps2dat_oe  <= 1'b0;
            tx_ready   <= 1'b1;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
            rx_inhibit <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    ps2clk_oe <= 1'b0;
                    ps2dat_oe <= 1'b0;
                    if (tx_valid) begin
                        shreg_r    <= tx_data;
                        parity_r   <= odd_parity(tx_data);
                        cnt_r      <= CNT_ZERO;
                        ps2clk_oe  <= 1'b1;
                        tx_ready   <= 1'b0;
                        rx_inhibit <= 1'b1;
                        state_r    <= ST_INHIBIT;
                    end else begin
                        tx_ready   <= 1'b1;
                        rx_inhibit <= 1'b0;
                    end
                end
                ST_INHIBIT: begin
                    if (cnt_r == INH_LAST) begin
                        ps2dat_oe <= 1'b1;
                        cnt_r     <= CNT_ZERO;
                        state_r   <= ST_REQ;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_REQ: begin
                    cnt_r     <= CNT_ZERO;
                    bitcnt_r  <= 4'd0;
                    ps2clk_oe <= 1'b0;
                    ps2dat_oe <= 1'b1;
                    state_r   <= ST_SEND;
                end
                ST_SEND, ST_ACK, ST_WAIT_REL: begin
                    if (cnt_r == WD_LAST) begin
                        // Watchdog wins over any edge seen in the same cycle.
                        ps2clk_oe  <= 1'b0;
                        ps2dat_oe  <= 1'b0;
                        tx_error   <= 1'b1;
                        tx_ready   <= 1'b1;
                        rx_inhibit <= 1'b0;
                        cnt_r      <= CNT_ZERO;
                        state_r    <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                        case (state_r)
                            ST_SEND: begin
                                if (fe_s) begin
                                    if (bitcnt_r == 4'd10) begin
`ifdef PS2_TX_ACK_CHECK_EN
                                        ack_bit_r <= dat_sync_r;
`endif
                                        ps2dat_oe <= 1'b0;
                                        state_r   <= ST_ACK;
                                    end else begin
                                        bitcnt_r  <= next_idx_s;
                                        ps2dat_oe <= ~next_bit_s;
                                    end
                                end
                            end
                            ST_ACK: begin
                                state_r <= ST_WAIT_REL;
                            end
                            ST_WAIT_REL: begin
                                if (clk_sync_r && dat_sync_r) begin
`ifdef PS2_TX_ACK_CHECK_EN
                                    tx_done  <= ~ack_bit_r;
                                    tx_error <= ack_bit_r;
`else
                                    tx_done  <= 1'b1;
`endif
                                    tx_ready   <= 1'b1;
                                    rx_inhibit <= 1'b0;
                                    cnt_r      <= CNT_ZERO;
                                    state_r    <= ST_IDLE;
                                end
                            end
                            default: begin
                                state_r <= ST_IDLE;
                            end
                        endcase
                    end
                end
                default: begin
                    ps2clk_oe  <= 1'b0;
                    ps2dat_oe  <= 1'b0;
                    tx_ready   <= 1'b1;
                    rx_inhibit <= 1'b0;
                    cnt_r      <= CNT_ZERO;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural keyboard clocking the open-drain lines.
module tb_ps2_host_tx;

    localparam int INH  = 50;
    localparam int TO   = 2000;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       reset, tx_valid;
    logic [7:0] tx_data;
    logic       ps2clk_oe, ps2dat_oe, tx_ready, tx_done, tx_error, rx_inhibit;
    logic       dev_clk_low, dev_dat_low;
    logic       ps2clk_line, ps2dat_line;

    assign ps2clk_line = ~(ps2clk_oe | dev_clk_low);
    assign ps2dat_line = ~(ps2dat_oe | dev_dat_low);

    always #20 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .CNT_W(19)) dut (
        .clk(clk), .reset(reset), .ps2clk(ps2clk_line), .ps2dat(ps2dat_line),
        .ps2clk_oe(ps2clk_oe), .ps2dat_oe(ps2dat_oe), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_done(tx_done), .tx_error(tx_error), .rx_inhibit(rx_inhibit)
    );

    int compared = 0, mismatched = 0;
    int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int req_cyc = 0, err_cyc = 0, clk_run = 0, inh_len = 0;

    // Pulse counters and line-timing monitor.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
        if (tx_error === 1'b1) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        if (tx_done === 1'b1 && tx_error === 1'b1) both_cnt <= both_cnt + 1;
        if (ps2clk_oe === 1'b1 && ps2dat_oe === 1'b1) req_cyc <= cyc;
        if (ps2clk_oe === 1'b1) clk_run <= clk_run + 1;
        else if (clk_run != 0) begin
            inh_len <= clk_run;
            clk_run <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Keyboard: wait for clock release with data low, then clock npulses, sampling on rising edges.
    task automatic dev_xfer(input int npulses, input bit ack_low, output logic [10:0] frame, output bit ok);
        frame = 11'h7FF;
        ok    = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (ps2clk_line === 1'b1 && ps2dat_line === 1'b0) ok = 1'b1;
        end
        if (ok) begin
            frame[0] = ps2dat_line;
            repeat (10) @(negedge clk);
            for (int p = 1; p <= npulses; p++) begin
                if (p == 11 && ack_low) dev_dat_low = 1'b1;
                repeat (5) @(negedge clk);
                dev_clk_low = 1'b1;
                repeat (HALF) @(negedge clk);
                dev_clk_low = 1'b0;
                repeat (4) @(negedge clk);
                if (p <= 10) frame[p] = ps2dat_line;
                repeat (HALF - 4) @(negedge clk);
            end
            dev_dat_low = 1'b0;
        end
    endtask

    task automatic wait_ready(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            if (tx_ready === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic expect_end(input string tag, input int d0, input int e0, input int exp_done, input int exp_err);
        bit ok;
        wait_ready(200, ok);
        chk({tag, "_end_seen"}, 32'(ok), 32'd1);
        @(negedge clk);
        chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'(exp_done));
        chk({tag, "_error_pulses"}, 32'(err_cnt - e0), 32'(exp_err));
    endtask

    logic [10:0] frame;
    bit          ok;
    int          d0, e0, clk_seen;
    logic [7:0]  s2_byte [3] = '{8'h00, 8'hFF, 8'h01};
    logic        s2_par  [3] = '{1'b1, 1'b1, 1'b0};
    int          nack_done, nack_err;

    initial begin
`ifdef PS2_TX_ACK_CHECK_EN
        nack_done = 0; nack_err = 1;
`else
        nack_done = 1; nack_err = 0;
`endif
        reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
        dev_clk_low = 1'b0; dev_dat_low = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_clk_oe", 32'(ps2clk_oe), 32'd0);
        chk("rst_dat_oe", 32'(ps2dat_oe), 32'd0);
        chk("rst_done", 32'(tx_done), 32'd0);
        chk("rst_error", 32'(tx_error), 32'd0);
        chk("rst_rx_inhibit", 32'(rx_inhibit), 32'd0);
        reset = 1'b0;

        // Scenario 1: 0xED
        d0 = done_cnt; e0 = err_cnt;
        send(8'hED);
        chk("s1_ready_busy", 32'(tx_ready), 32'd0);
        chk("s1_rx_inhibit", 32'(rx_inhibit), 32'd1);
        chk("s1_clk_pulled", 32'(ps2clk_oe), 32'd1);
        dev_xfer(11, 1'b1, frame, ok);
        chk("s1_release", 32'(ok), 32'd1);
        chk("s1_start", 32'(frame[0]), 32'd0);
        chk("s1_data", 32'(frame[8:1]), 32'hED);
        chk("s1_parity", 32'(frame[9]), 32'd1);
        chk("s1_stop", 32'(frame[10]), 32'd1);
        expect_end("s1", d0, e0, 1, 0);
        chk("s1_inhibit_len_ok", 32'(inh_len >= INH), 32'd1);

        // Scenario 2: parity on 0x00, 0xFF, 0x01
        for (int k = 0; k < 3; k++) begin
            d0 = done_cnt; e0 = err_cnt;
            send(s2_byte[k]);
            dev_xfer(11, 1'b1, frame, ok);
            chk("s2_data", 32'(frame[8:1]), 32'(s2_byte[k]));
            chk("s2_parity", 32'(frame[9]), 32'(s2_par[k]));
            expect_end("s2", d0, e0, 1, 0);
        end

        // Scenario 3: device stops after 4 clocks
        d0 = done_cnt; e0 = err_cnt;
        send(8'hFF);
        dev_xfer(4, 1'b1, frame, ok);
        chk("s3_partial_bits", 32'(frame[4:0]), 32'h1E);
        wait_ready(TO + 200, ok);
        chk("s3_timeout_seen", 32'(ok), 32'd1);
        @(negedge clk);
        chk("s3_next_clk_oe", 32'(ps2clk_oe), 32'd0);
        chk("s3_next_dat_oe", 32'(ps2dat_oe), 32'd0);
        chk("s3_next_ready", 32'(tx_ready), 32'd1);
        chk("s3_error_pulses", 32'(err_cnt - e0), 32'd1);
        chk("s3_done_pulses", 32'(done_cnt - d0), 32'd0);
        chk("s3_timeout_cycles", 32'(err_cyc - req_cyc), 32'(TO));

        // Scenario 4: device answers NACK
        d0 = done_cnt; e0 = err_cnt;
        send(8'hF4);
        dev_xfer(11, 1'b0, frame, ok);
        chk("s4_data", 32'(frame[8:1]), 32'hF4);
        expect_end("s4", d0, e0, nack_done, nack_err);

        // Scenario 5: reset at bitcnt 5, then 0x55
        d0 = done_cnt; e0 = err_cnt;
        send(8'h3C);
        dev_xfer(5, 1'b1, frame, ok);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("s5_clk_oe", 32'(ps2clk_oe), 32'd0);
        chk("s5_dat_oe", 32'(ps2dat_oe), 32'd0);
        chk("s5_ready", 32'(tx_ready), 32'd1);
        chk("s5_rx_inhibit", 32'(rx_inhibit), 32'd0);
        @(negedge clk);
        chk("s5_no_pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
        send(8'h55);
        dev_xfer(11, 1'b1, frame, ok);
        chk("s5_data", 32'(frame[8:1]), 32'h55);
        chk("s5_parity", 32'(frame[9]), 32'd1);
        expect_end("s5", d0, e0, 1, 0);

        // Scenario 6: request while busy is dropped
        d0 = done_cnt; e0 = err_cnt;
        send(8'hED);
        repeat (10) @(negedge clk);
        chk("s6_ready_in_inhibit", 32'(tx_ready), 32'd0);
        tx_data = 8'h12; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        dev_xfer(11, 1'b1, frame, ok);
        chk("s6_data", 32'(frame[8:1]), 32'hED);
        expect_end("s6", d0, e0, 1, 0);
        clk_seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (ps2clk_oe !== 1'b0) clk_seen++;
        end
        chk("s6_not_queued", 32'(clk_seen), 32'd0);

        chk("never_both_pulses", 32'(both_cnt), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
